// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types, encodings and forwarding select helper
package pipeline_pkg;

  typedef enum logic [1:0] {
    FWD_RD  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
  localparam logic [4:0] REG_X0          = 5'd0;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       regwrite;
    logic       load;
  } e_stage_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       regwrite;
  } wb_stage_t;

  // M is the younger producer, so it shadows W; x0 is never a forwarding source.
  function automatic fwd_sel_t fwd_select(input logic [4:0] rs, input wb_stage_t m,
                                          input wb_stage_t w);
    fwd_sel_t sel;
    sel = FWD_RD;
    if (m.regwrite && (m.rd != REG_X0) && (m.rd == rs))
      sel = FWD_MEM;
    else if (w.regwrite && (w.rd != REG_X0) && (w.rd == rs))
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - forwarding, load-use stall and branch flush control with perf counters
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             RegWriteD,
  input  logic [1:0]       ResultSrcD,
  input  logic             PCSrcE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  import pipeline_pkg::*;

  e_stage_t  e_q;
  e_stage_t  e_d;
  wb_stage_t m_q;
  wb_stage_t w_q;
  logic      lw_stall;

  always_comb begin
    e_d          = '0;
    e_d.rs1      = Rs1D;
    e_d.rs2      = Rs2D;
    e_d.rd       = RdD;
    e_d.regwrite = RegWriteD;
    e_d.load     = (ResultSrcD == RESULT_SRC_LOAD);
    if (FlushE)
      e_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q         <= e_d;
      m_q.rd      <= e_q.rd;
      m_q.regwrite <= e_q.regwrite;
      w_q         <= m_q;
    end
  end

  assign ForwardAE = fwd_select(e_q.rs1, m_q, w_q);
  assign ForwardBE = fwd_select(e_q.rs2, m_q, w_q);

  // Rs fields are compared unconditionally; an occasional spurious stall is harmless.
  assign lw_stall = e_q.load && (e_q.rd != REG_X0) && ((e_q.rd == Rs1D) || (e_q.rd == Rs2D));

  // A taken branch overrides the stall so the target can be fetched.
  assign StallF = lw_stall && !PCSrcE;
  assign StallD = lw_stall && !PCSrcE;
  assign FlushD = PCSrcE;
  assign FlushE = lw_stall || PCSrcE;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (StallD),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (PCSrcE),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed and randomized self-checking bench for hazard_unit
module tb_hazard_unit;
  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [4:0]       Rs1D = '0, Rs2D = '0, RdD = '0;
  logic             RegWriteD = 1'b0;
  logic [1:0]       ResultSrcD = '0;
  logic             PCSrcE = 1'b0;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, FlushD, FlushE;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .PCSrcE(PCSrcE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Instruction records in flight: index 0 = E, 1 = M, 2 = W.
  typedef struct {
    int rs1;
    int rs2;
    int rd;
    bit wr;
    bit ld;
  } rec_t;

  rec_t pipe[3];
  int   m_scnt = 0;
  int   m_fcnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest older instruction writing the register supplies it: M gives 2, W gives 1.
  function automatic int m_fwd(input int rs);
    for (int s = 1; s <= 2; s++)
      if (pipe[s].wr && pipe[s].rd != 0 && pipe[s].rd == rs)
        return (s == 1) ? 2 : 1;
    return 0;
  endfunction

  function automatic bit m_lw();
    return pipe[0].ld && pipe[0].rd != 0 &&
           (pipe[0].rd == int'(Rs1D) || pipe[0].rd == int'(Rs2D));
  endfunction

  initial for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 1'b0, 1'b0};

  always @(posedge clk) begin
    rec_t nr;
    bit ls;
    if (reset) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 1'b0, 1'b0};
      m_scnt = 0;
      m_fcnt = 0;
    end else begin
      ls = m_lw();
      if (ls && !PCSrcE) m_scnt = (m_scnt < MAXC) ? m_scnt + 1 : MAXC;
      if (PCSrcE)        m_fcnt = (m_fcnt < MAXC) ? m_fcnt + 1 : MAXC;
      if (ls || PCSrcE) nr = '{0, 0, 0, 1'b0, 1'b0};
      else nr = '{int'(Rs1D), int'(Rs2D), int'(RdD), RegWriteD, ResultSrcD == 2'b01};
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nr;
    end
  end

  always @(negedge clk) begin
    bit ls;
    if (chk_on) begin
      ls = m_lw();
      chk("model_fwda", int'(ForwardAE), m_fwd(pipe[0].rs1));
      chk("model_fwdb", int'(ForwardBE), m_fwd(pipe[0].rs2));
      chk("model_stallf", int'(StallF), int'(ls && !PCSrcE));
      chk("model_stalld", int'(StallD), int'(ls && !PCSrcE));
      chk("model_flushd", int'(FlushD), int'(PCSrcE));
      chk("model_flushe", int'(FlushE), int'(ls || PCSrcE));
      chk("model_stall_cnt", int'(stall_cnt), m_scnt);
      chk("model_flush_cnt", int'(flush_cnt), m_fcnt);
    end
  end

  task automatic cyc(input int rs1, input int rs2, input int rd, input bit rw,
                     input bit ld, input bit pc, input bit rst);
    @(posedge clk);
    #1;
    Rs1D       = 5'(rs1);
    Rs2D       = 5'(rs2);
    RdD        = 5'(rd);
    RegWriteD  = rw;
    ResultSrcD = ld ? 2'b01 : 2'b00;
    PCSrcE     = pc;
    reset      = rst;
    @(negedge clk);
  endtask

  task automatic nop();
    cyc(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  int sc0;
  int fc0;

  initial begin
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("rst_fwda", int'(ForwardAE), 0);
    chk("rst_fwdb", int'(ForwardBE), 0);
    chk("rst_stalld", int'(StallD), 0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("rst_flushd_pc", int'(FlushD), 1);
    chk("rst_flushe_pc", int'(FlushE), 1);
    chk("rst_stallf_pc", int'(StallF), 0);
    chk_on = 1'b1;
    nop();
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    chk("rst_flush_cnt", int'(flush_cnt), 0);
    chk("rst_flushe", int'(FlushE), 0);

    // add x5 ; sub x?,x5,x6 -> M forward on A only
    cyc(1, 2, 5, 1, 0, 0, 0);
    cyc(5, 6, 8, 1, 0, 0, 0);
    nop();
    chk("m_fwd_a", int'(ForwardAE), 2);
    chk("m_fwd_b", int'(ForwardBE), 0);
    chk("m_fwd_nostall", int'(StallD), 0);

    // add x5 ; nop ; or x?,x1,x5 -> W forward on B
    cyc(1, 2, 5, 1, 0, 0, 0);
    nop();
    cyc(1, 5, 9, 1, 0, 0, 0);
    nop();
    chk("w_fwd_b", int'(ForwardBE), 1);
    chk("w_fwd_a", int'(ForwardAE), 0);

    // two writers of x7 -> M wins
    cyc(1, 1, 7, 1, 0, 0, 0);
    cyc(2, 2, 7, 1, 0, 0, 0);
    cyc(7, 3, 10, 1, 0, 0, 0);
    nop();
    chk("m_priority", int'(ForwardAE), 2);

    // addi x0 ; reader of x0
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 11, 1, 0, 0, 0);
    nop();
    chk("x0_fwd_a", int'(ForwardAE), 0);
    chk("x0_fwd_b", int'(ForwardBE), 0);

    // lw x3 ; add x4,x3,x3 -> one stall, then W forward on both
    nop(); nop(); nop();
    sc0 = int'(stall_cnt);
    cyc(1, 0, 3, 1, 1, 0, 0);
    cyc(3, 3, 4, 1, 0, 0, 0);
    chk("lu_stallf", int'(StallF), 1);
    chk("lu_stalld", int'(StallD), 1);
    chk("lu_flushe", int'(FlushE), 1);
    cyc(3, 3, 4, 1, 0, 0, 0);
    chk("lu_one_cycle", int'(StallD), 0);
    chk("lu_cnt", int'(stall_cnt), sc0 + 1);
    nop();
    chk("lu_fwd_a", int'(ForwardAE), 1);
    chk("lu_fwd_b", int'(ForwardBE), 1);

    // load-use coinciding with taken branch -> flush wins
    nop(); nop();
    sc0 = int'(stall_cnt);
    fc0 = int'(flush_cnt);
    cyc(1, 0, 3, 1, 1, 0, 0);
    cyc(3, 0, 4, 1, 0, 1, 0);
    chk("br_stallf", int'(StallF), 0);
    chk("br_stalld", int'(StallD), 0);
    chk("br_flushd", int'(FlushD), 1);
    chk("br_flushe", int'(FlushE), 1);
    nop();
    chk("br_flush_cnt", int'(flush_cnt), fc0 + 1);
    chk("br_stall_cnt", int'(stall_cnt), sc0);

    // reset asserted while a load-use stall is showing
    cyc(1, 0, 3, 1, 1, 0, 0);
    cyc(0, 3, 4, 1, 0, 0, 1);
    chk("rs_stall_before", int'(StallD), 1);
    cyc(0, 3, 4, 1, 0, 0, 0);
    chk("rs_stall_dropped", int'(StallD), 0);
    chk("rs_stall_cnt", int'(stall_cnt), 0);
    chk("rs_flush_cnt", int'(flush_cnt), 0);

    // 2^CNT_W+3 load-use stalls -> counter pinned at all-ones
    for (int i = 0; i < MAXC + 4; i++) begin
      cyc(1, 0, 3, 1, 1, 0, 0);
      cyc(3, 0, 4, 1, 0, 0, 0);
    end
    nop();
    chk("sat_stall_cnt", int'(stall_cnt), MAXC);

    // randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 299) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
